// File: rtl/ecliptic_minmax_reduce.sv
// ecliptic_minmax_reduce
// Streaming IEEE-754 min/max reduction. It accepts a burst of 1..MAX_N operands,
// one per cycle, ended by 'last' or by reaching MAX_N operands. One cycle after the
// final operand it pulses 'ack' and presents the minimum, maximum, count and flags.
// NaN operands are ignored for ordering, as in RISC-V fmin/fmax. -0 orders below +0.
// When no operand in the burst is a number, both results are the canonical NaN.
// An sNaN anywhere in the burst raises nv.
// Optional feature: define ECLIPTIC_REDUCE_INDEX_EN to track the 0-based burst index
// of the selected minimum and maximum. Without it, min_idx/max_idx are constant 0.
module ecliptic_minmax_reduce #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MAX_N  = 16,
    localparam int W     = 1 + EXP_W + FRAC_W,
    localparam int CNT_W = $clog2(MAX_N + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req,
    input  logic [W-1:0]     src,
    input  logic             last,
    output logic             busy,
    output logic             ack,
    output logic [W-1:0]     minimum,
    output logic [W-1:0]     maximum,
    output logic [CNT_W-1:0] count,
    output logic             nv,
    output logic             overflow,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
);

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_N);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} stateT;

    stateT             state;
    logic              haveNum;
    logic [W-1:0]      accMin;
    logic [W-1:0]      accMax;
    logic [CNT_W-1:0]  accCnt;
    logic              accNv;

    logic              baseHave;
    logic [W-1:0]      baseMin;
    logic [W-1:0]      baseMax;
    logic [CNT_W-1:0]  baseCnt;
    logic              baseNv;
    logic              srcNan;
    logic              srcSnan;
    logic              minUpd;
    logic              maxUpd;
    logic              nxtHave;
    logic [W-1:0]      nxtMin;
    logic [W-1:0]      nxtMax;
    logic [CNT_W-1:0]  nxtCnt;
    logic              nxtNv;
    logic              hitMax;
    logic              finalOp;

    // Strict sign-magnitude "a < b" on raw encodings of non-NaN values. A sign
    // difference is decided by the sign alone, which makes -0 < +0.
    function automatic logic lessThan(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a[W-1] != b[W-1]) begin
            return a[W-1];
        end else if (a[W-1]) begin
            return a[W-2:0] > b[W-2:0];
        end else begin
            return a[W-2:0] < b[W-2:0];
        end
    endfunction

    // Fold the incoming operand into the running state. A burst starts fresh in IDLE.
    // Only a strictly better value replaces the current one, so the first of equal values wins.
    always_comb begin
        baseHave = (state == ACCUM) ? haveNum : 1'b0;
        baseMin  = (state == ACCUM) ? accMin  : '0;
        baseMax  = (state == ACCUM) ? accMax  : '0;
        baseCnt  = (state == ACCUM) ? accCnt  : '0;
        baseNv   = (state == ACCUM) ? accNv   : 1'b0;
        srcNan   = (src[W-2:FRAC_W] == {EXP_W{1'b1}}) && (src[FRAC_W-1:0] != '0);
        srcSnan  = srcNan && !src[FRAC_W-1];
        minUpd   = !srcNan && (!baseHave || lessThan(src, baseMin));
        maxUpd   = !srcNan && (!baseHave || lessThan(baseMax, src));
        nxtHave  = baseHave || !srcNan;
        nxtMin   = minUpd ? src : baseMin;
        nxtMax   = maxUpd ? src : baseMax;
        nxtCnt   = baseCnt + CNT_W'(1);
        nxtNv    = baseNv || srcSnan;
        hitMax   = (nxtCnt == MAX_CNT);
        finalOp  = last || hitMax;
    end

    // Burst FSM plus the accumulators and the result registers. Results load
    // together with the ack pulse and hold until the next ack or reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            haveNum  <= 1'b0;
            accMin   <= '0;
            accMax   <= '0;
            accCnt   <= '0;
            accNv    <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            minimum  <= '0;
            maximum  <= '0;
            count    <= '0;
            nv       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ack  <= 1'b0;
            busy <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (req) begin
                        haveNum <= nxtHave;
                        accMin  <= nxtMin;
                        accMax  <= nxtMax;
                        accCnt  <= nxtCnt;
                        accNv   <= nxtNv;
                        if (finalOp) begin
                            state    <= DONE;
                            busy     <= 1'b1;
                            ack      <= 1'b1;
                            minimum  <= nxtHave ? nxtMin : CANON_NAN;
                            maximum  <= nxtHave ? nxtMax : CANON_NAN;
                            count    <= nxtCnt;
                            nv       <= nxtNv;
                            overflow <= hitMax && !last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ECLIPTIC_REDUCE_INDEX_EN
    logic [CNT_W-1:0] accMinIdx;
    logic [CNT_W-1:0] accMaxIdx;
    logic [CNT_W-1:0] nxtMinIdx;
    logic [CNT_W-1:0] nxtMaxIdx;

    // The index of the operand is the count before it, taken whenever that operand wins.
    always_comb begin
        nxtMinIdx = minUpd ? baseCnt : ((state == ACCUM) ? accMinIdx : '0);
        nxtMaxIdx = maxUpd ? baseCnt : ((state == ACCUM) ? accMaxIdx : '0);
    end

    // Track the winning indices in step with the value accumulators.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            accMinIdx <= '0;
            accMaxIdx <= '0;
            min_idx   <= '0;
            max_idx   <= '0;
        end else if (state != DONE && req) begin
            accMinIdx <= nxtMinIdx;
            accMaxIdx <= nxtMaxIdx;
            if (finalOp) begin
                min_idx <= nxtMinIdx;
                max_idx <= nxtMaxIdx;
            end
        end
    end
`else
    assign min_idx = '0;
    assign max_idx = '0;
`endif

endmodule

// File: tb/tb_ecliptic_minmax_reduce.sv
// Testbench for ecliptic_minmax_reduce (binary32 defaults).
// Directed bursts. A reference model computes the expected result of each
// burst from the list of accepted operands. A negedge monitor checks every ack
// and verifies that the outputs hold between acks. Literal expectations taken
// from hand-worked vectors pin the model.
module tb_ecliptic_minmax_reduce;

    logic        clk;
    logic        nrst;
    logic        req;
    logic [31:0] src;
    logic        last;
    logic        busy;
    logic        ack;
    logic [31:0] minimum;
    logic [31:0] maximum;
    logic [4:0]  count;
    logic        nv;
    logic        overflow;
    logic [4:0]  min_idx;
    logic [4:0]  max_idx;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [4:0]  cnt;
        logic        nv;
        logic        ovf;
        logic [4:0]  mnIdx;
        logic [4:0]  mxIdx;
    } expT;

    int          nChecks = 0;
    int          nPass   = 0;
    expT         expectQ[$];
    expT         holdExp = '{default: 0};
    logic [31:0] accQ[$];

    ecliptic_minmax_reduce dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .src      (src),
        .last     (last),
        .busy     (busy),
        .ack      (ack),
        .minimum  (minimum),
        .maximum  (maximum),
        .count    (count),
        .nv       (nv),
        .overflow (overflow),
        .min_idx  (min_idx),
        .max_idx  (max_idx)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Total-order key: an unsigned compare of the keys orders the floats with -0 below +0
    function automatic logic [31:0] orderKey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Reference result of a burst, given its accepted operands
    function automatic expT model(input logic [31:0] q[$], input logic ovf);
        expT e = '{default: 0};
        bit  have = 0;
        foreach (q[i]) begin
            logic [31:0] x = q[i];
            bit isNan = (x[30:23] == 8'hff) && (x[22:0] != 0);
            if (isNan && !x[22]) e.nv = 1'b1;
            if (!isNan) begin
                if (!have || orderKey(x) < orderKey(e.mn)) begin e.mn = x; e.mnIdx = 5'(i); end
                if (!have || orderKey(x) > orderKey(e.mx)) begin e.mx = x; e.mxIdx = 5'(i); end
                have = 1;
            end
        end
        if (!have) begin e.mn = 32'h7fc0_0000; e.mx = 32'h7fc0_0000; end
        e.cnt = 5'(q.size());
        e.ovf = ovf;
        return e;
    endfunction

    // Monitor: every ack must match the next expected burst; otherwise outputs hold
    always @(negedge clk) begin
        if (nrst) begin
            if (ack) begin
                if (expectQ.size() == 0) checkOutput("spurious ack", 32'(ack), 32'd0);
                else holdExp = expectQ.pop_front();
            end
            checkOutput("mon busy", 32'(busy), 32'(ack));
            checkOutput("mon minimum", minimum, holdExp.mn);
            checkOutput("mon maximum", maximum, holdExp.mx);
            checkOutput("mon count", 32'(count), 32'(holdExp.cnt));
            checkOutput("mon nv", 32'(nv), 32'(holdExp.nv));
            checkOutput("mon overflow", 32'(overflow), 32'(holdExp.ovf));
`ifdef ECLIPTIC_REDUCE_INDEX_EN
            checkOutput("mon min_idx", 32'(min_idx), 32'(holdExp.mnIdx));
            checkOutput("mon max_idx", 32'(max_idx), 32'(holdExp.mxIdx));
`else
            checkOutput("mon min_idx", 32'(min_idx), 32'd0);
            checkOutput("mon max_idx", 32'(max_idx), 32'd0);
`endif
        end
    end

    // Drive one operand; if it ends the burst, queue the expected result and check ack latency
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        @(posedge clk); #1;
        req = 1'b1; src = d; last = l;
        accQ.push_back(d);
        if (l || accQ.size() == 16) begin
            expectQ.push_back(model(accQ, !l));
            accQ.delete();
            @(posedge clk); #1;
            req = 1'b0; last = 1'b0;
            checkOutput("ack latency", 32'(ack), 32'd1);
            checkOutput("busy in done", 32'(busy), 32'd1);
        end
    endtask

    // Idle cycle, optionally with last asserted and req low
    task automatic bubble(input logic l);
        @(posedge clk); #1;
        req = 1'b0; last = l;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        req = 1'b0; last = 1'b0; nrst = 1'b0;
        accQ.delete();
        expectQ.delete();
        holdExp = '{default: 0};
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0; req = 1'b0; last = 1'b0; src = '0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        checkOutput("reset ack", 32'(ack), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset minimum", minimum, 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);

        // 1: basic two operand burst
        applyStimulus(32'h3f80_0000, 1'b0);
        applyStimulus(32'hcf80_0000, 1'b1);
        checkOutput("t1 min", minimum, 32'hcf80_0000);
        checkOutput("t1 max", maximum, 32'h3f80_0000);
        checkOutput("t1 count", 32'(count), 32'd2);
        checkOutput("t1 nv", 32'(nv), 32'd0);

        // 2: qNaN ignored
        applyStimulus(32'h7fc0_0000, 1'b0);
        applyStimulus(32'h3f80_0000, 1'b1);
        checkOutput("t2 min", minimum, 32'h3f80_0000);
        checkOutput("t2 max", maximum, 32'h3f80_0000);
        checkOutput("t2 nv", 32'(nv), 32'd0);
`ifdef ECLIPTIC_REDUCE_INDEX_EN
        checkOutput("t2 min_idx", 32'(min_idx), 32'd1);
        checkOutput("t2 max_idx", 32'(max_idx), 32'd1);
`endif

        // 3: signed zeros
        applyStimulus(32'h8000_0000, 1'b0);
        applyStimulus(32'h0000_0000, 1'b1);
        checkOutput("t3 min", minimum, 32'h8000_0000);
        checkOutput("t3 max", maximum, 32'h0000_0000);

        // 4: single sNaN
        applyStimulus(32'h7f80_0001, 1'b1);
        checkOutput("t4 min", minimum, 32'h7fc0_0000);
        checkOutput("t4 max", maximum, 32'h7fc0_0000);
        checkOutput("t4 nv", 32'(nv), 32'd1);
        checkOutput("t4 count", 32'(count), 32'd1);

        // 5: overflow after 16 operands, then req during DONE is ignored
        for (int i = 1; i <= 16; i++) applyStimulus(32'(i), 1'b0);
        checkOutput("t5 overflow", 32'(overflow), 32'd1);
        checkOutput("t5 min", minimum, 32'h0000_0001);
        checkOutput("t5 max", maximum, 32'h0000_0010);
        checkOutput("t5 count", 32'(count), 32'd16);
        req = 1'b1; src = 32'h3f80_0000; last = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; last = 1'b0;
        repeat (3) @(posedge clk); #1;
        checkOutput("t5 done req ignored", 32'(count), 32'd16);

        // last without req is ignored; equal minimums keep the first occurrence
        applyStimulus(32'hc000_0000, 1'b0);
        bubble(1'b1);
        applyStimulus(32'h3f80_0000, 1'b0);
        applyStimulus(32'hc000_0000, 1'b1);
        checkOutput("gap min", minimum, 32'hc000_0000);
        checkOutput("gap max", maximum, 32'h3f80_0000);
        checkOutput("gap count", 32'(count), 32'd3);
        checkOutput("gap overflow", 32'(overflow), 32'd0);

        // infinities and subnormals
        applyStimulus(32'h0000_0001, 1'b0);
        applyStimulus(32'hff80_0000, 1'b0);
        applyStimulus(32'h7f80_0000, 1'b0);
        applyStimulus(32'h8000_0001, 1'b1);
        checkOutput("inf min", minimum, 32'hff80_0000);
        checkOutput("inf max", maximum, 32'h7f80_0000);

        // 6: reset mid-burst, then a fresh burst
        applyStimulus(32'h4040_0000, 1'b0);
        applyStimulus(32'h4080_0000, 1'b0);
        applyStimulus(32'h40a0_0000, 1'b0);
        doReset();
        repeat (3) @(posedge clk); #1;
        checkOutput("t6 ack after reset", 32'(ack), 32'd0);
        checkOutput("t6 min after reset", minimum, 32'd0);
        checkOutput("t6 count after reset", 32'(count), 32'd0);
        applyStimulus(32'h4000_0000, 1'b1);
        checkOutput("t6 min", minimum, 32'h4000_0000);
        checkOutput("t6 max", maximum, 32'h4000_0000);

        repeat (4) @(posedge clk); #1;
        checkOutput("expect queue drained", 32'(expectQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
